// File: rtl/sram_mem_controller_if.sv
// Bus bundle between the MEM stage and the SRAM controller, plus the
// SRAM pin-side signals. The controller uses the slave view.
interface sram_mem_controller_if #(
    parameter int SRAM_AW = 18
);
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        address;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport slave (
        input  rd_en, wr_en, address, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );

    modport master (
        output rd_en, wr_en, address, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/sram_mem_controller.sv
// Word-to-half-word SRAM controller. A 32-bit MEM-stage access becomes a
// LO then HI half-word access, each WAIT_CYCLES clocks long. ready stays
// low from the request cycle until the single DONE cycle.
module sram_mem_controller #(
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_mem_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state, next_state;
    logic [3:0]  counter;
    logic        is_wr;
    logic        op;
    logic        last;
    logic [31:0] offset;
    logic        unused_offset;

    assign op     = bus.rd_en | bus.wr_en;
    assign last   = (counter == LAST);
    // Modular subtraction: addresses below BASE_ADDR wrap to the top of SRAM.
    assign offset = bus.address - 32'(BASE_ADDR);
    assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic: each phase lasts WAIT_CYCLES cycles, DONE always
    // drops back to IDLE so back-to-back requests see one IDLE cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (op)   next_state = LO;
            LO:      if (last) next_state = HI;
            HI:      if (last) next_state = DONE;
            default:           next_state = IDLE;
        endcase
    end

    // Datapath: phase counter, latched op type, SRAM address/data and read
    // capture. Address and write data change only at phase boundaries so
    // they are stable around the we_n rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter         <= '0;
            is_wr           <= 1'b0;
            bus.rdata       <= '0;
            bus.sram_addr   <= '0;
            bus.sram_dq_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    counter <= '0;
                    if (op) begin
                        is_wr         <= bus.wr_en;   // write wins over read
                        bus.sram_addr <= {offset[SRAM_AW:2], 1'b0};
                        if (bus.wr_en) bus.sram_dq_out <= bus.wdata[15:0];
                    end
                end
                LO: begin
                    if (last) begin
                        counter          <= '0;
                        bus.sram_addr[0] <= 1'b1;
                        if (is_wr) bus.sram_dq_out   <= bus.wdata[31:16];
                        else       bus.rdata[15:0]   <= bus.sram_dq_in;
                    end else begin
                        counter <= counter + 4'd1;
                    end
                end
                HI: begin
                    if (last) begin
                        counter <= '0;
                        if (!is_wr) bus.rdata[31:16] <= bus.sram_dq_in;
                    end else begin
                        counter <= counter + 4'd1;
                    end
                end
                default: counter <= '0;
            endcase
        end
    end

    // Outputs: strobes per phase; we_n rises on the last cycle of a write
    // phase to give address/data hold time.
    always_comb begin
        bus.ready      = 1'b0;
        bus.sram_dq_oe = 1'b0;
        bus.sram_we_n  = 1'b1;
        bus.sram_oe_n  = 1'b1;
        case (state)
            IDLE: bus.ready = !op;
            LO, HI: begin
                if (is_wr) begin
                    bus.sram_dq_oe = 1'b1;
                    bus.sram_we_n  = last;
                end else begin
                    bus.sram_oe_n  = 1'b0;
                end
            end
            default: bus.ready = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller: a WAIT_CYCLES=3 instance backed
// by a behavioural SRAM, and a WAIT_CYCLES=2 instance for address wrap.
module tb_sram_mem_controller;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   wr_cycles = 0;

    always #5 clk = ~clk;

    sram_mem_controller_if #(.SRAM_AW(18)) bus1 ();
    sram_mem_controller_if #(.SRAM_AW(18)) bus2 ();

    sram_mem_controller #(.WAIT_CYCLES(3), .BASE_ADDR(1024), .SRAM_AW(18)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));
    sram_mem_controller #(.WAIT_CYCLES(2), .BASE_ADDR(1024), .SRAM_AW(18)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));

    // Behavioural SRAM: sampled mid-cycle, a write lands each cycle we_n is low.
    logic [15:0] mem [0:(1<<18)-1];
    always @(negedge clk) begin
        if (bus1.sram_we_n === 1'b0) begin
            wr_cycles = wr_cycles + 1;
            if (bus1.sram_dq_oe === 1'b1) mem[bus1.sram_addr] = bus1.sram_dq_out;
        end
    end
    assign bus1.sram_dq_in = bus1.sram_oe_n ? 16'h0 : mem[bus1.sram_addr];
    assign bus2.sram_dq_in = 16'h0;

    // Presents a request on bus1 and measures cycles until ready returns.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, output int stall, output int we_cnt,
                              output bit oe_seen, output logic [31:0] rd_val);
        @(posedge clk); #1;
        bus1.rd_en = rd; bus1.wr_en = wr; bus1.address = addr; bus1.wdata = wd;
        stall = 0; we_cnt = 0; oe_seen = 0;
        @(negedge clk);
        while (bus1.ready !== 1'b1 && stall < 40) begin
            stall++;
            if (bus1.sram_we_n === 1'b0) we_cnt++;
            if (bus1.sram_dq_oe !== 1'b0) oe_seen = 1;
            @(negedge clk);
        end
        rd_val = bus1.rdata;
    endtask

    task automatic idle1();
        @(posedge clk); #1;
        bus1.rd_en = 0; bus1.wr_en = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.rd_en = 0; bus1.wr_en = 0; bus1.address = 0; bus1.wdata = 0;
        bus2.rd_en = 0; bus2.wr_en = 0; bus2.address = 0; bus2.wdata = 0;
        repeat (2) @(negedge clk);
        vectors++; if (bus1.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", bus1.ready); end
        vectors++; if (bus1.sram_we_n !== 1'b1 || bus1.sram_oe_n !== 1'b1 || bus1.sram_dq_oe !== 1'b0) begin
            miscompares++; $display("FAIL reset_strobes got we_n=%b oe_n=%b dq_oe=%b want 1 1 0", bus1.sram_we_n, bus1.sram_oe_n, bus1.sram_dq_oe); end
        vectors++; if (bus1.rdata !== 32'h0 || bus1.sram_addr !== 18'h0 || bus1.sram_dq_out !== 16'h0) begin
            miscompares++; $display("FAIL reset_regs got rdata=%h addr=%h dq=%h want 0", bus1.rdata, bus1.sram_addr, bus1.sram_dq_out); end
        vectors++; if (bus2.ready !== 1'b1 || bus2.sram_we_n !== 1'b1) begin
            miscompares++; $display("FAIL reset_dut2 got ready=%b we_n=%b want 1 1", bus2.ready, bus2.sram_we_n); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int stall, we_cnt; bit oe; logic [31:0] r;
        run_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, stall, we_cnt, oe, r);
        idle1();
        vectors++; if (stall != 7) begin miscompares++; $display("FAIL write_stall got %0d want 7", stall); end
        vectors++; if (we_cnt != 4) begin miscompares++; $display("FAIL write_we_low got %0d want 4", we_cnt); end
        vectors++; if (mem[4] !== 16'hBEEF) begin miscompares++; $display("FAIL write_lo got %h want beef", mem[4]); end
        vectors++; if (mem[5] !== 16'hDEAD) begin miscompares++; $display("FAIL write_hi got %h want dead", mem[5]); end
    endtask

    task automatic test_read();
        int stall, we_cnt; bit oe; logic [31:0] r;
        mem[4] = 16'h1234; mem[5] = 16'hABCD;
        run_access(1'b1, 1'b0, 32'd1032, 32'h0, stall, we_cnt, oe, r);
        idle1();
        vectors++; if (stall != 7) begin miscompares++; $display("FAIL read_stall got %0d want 7", stall); end
        vectors++; if (r !== 32'hABCD1234) begin miscompares++; $display("FAIL read_data got %h want abcd1234", r); end
        vectors++; if (oe || we_cnt != 0) begin miscompares++; $display("FAIL read_strobes got dq_oe_seen=%0d we_low=%0d want 0 0", oe, we_cnt); end
    endtask

    task automatic test_back_to_back();
        int s1, s2, w1, w2; bit o1, o2; logic [31:0] r1, r2;
        run_access(1'b0, 1'b1, 32'd1024, 32'h11112222, s1, w1, o1, r1);
        run_access(1'b1, 1'b0, 32'd1024, 32'h0, s2, w2, o2, r2);
        idle1();
        vectors++; if (s1 != 7) begin miscompares++; $display("FAIL b2b_write_stall got %0d want 7", s1); end
        vectors++; if (s2 != 7) begin miscompares++; $display("FAIL b2b_read_stall got %0d want 7", s2); end
        vectors++; if (r2 !== 32'h11112222) begin miscompares++; $display("FAIL b2b_read_data got %h want 11112222", r2); end
    endtask

    task automatic test_both_enables();
        int stall, we_cnt; bit oe; logic [31:0] r;
        run_access(1'b1, 1'b1, 32'd1028, 32'h5A5A0F0F, stall, we_cnt, oe, r);
        idle1();
        vectors++; if (mem[2] !== 16'h0F0F || mem[3] !== 16'h5A5A) begin
            miscompares++; $display("FAIL both_write got %h %h want 0f0f 5a5a", mem[2], mem[3]); end
        vectors++; if (r !== 32'h11112222) begin miscompares++; $display("FAIL both_rdata got %h want 11112222", r); end
        vectors++; if (we_cnt != 4) begin miscompares++; $display("FAIL both_we_low got %0d want 4", we_cnt); end
    endtask

    task automatic test_wrap();
        int c; logic [17:0] a_lo, a_hi;
        a_lo = '0; a_hi = '0;
        @(posedge clk); #1;
        bus2.rd_en = 1'b1; bus2.address = 32'd1020;
        c = 0;
        @(negedge clk);
        while (bus2.ready !== 1'b1 && c < 40) begin
            if (c == 1) a_lo = bus2.sram_addr;
            if (c == 3) a_hi = bus2.sram_addr;
            c++;
            @(negedge clk);
        end
        @(posedge clk); #1 bus2.rd_en = 1'b0;
        vectors++; if (a_lo !== 18'h3FFFE) begin miscompares++; $display("FAIL wrap_lo_addr got %h want 3fffe", a_lo); end
        vectors++; if (a_hi !== 18'h3FFFF) begin miscompares++; $display("FAIL wrap_hi_addr got %h want 3ffff", a_hi); end
        vectors++; if (c != 5) begin miscompares++; $display("FAIL wrap_stall got %0d want 5", c); end
    endtask

    task automatic test_reset_mid();
        int w0;
        @(posedge clk); #1;
        bus1.wr_en = 1'b1; bus1.address = 32'd1040; bus1.wdata = 32'hCAFEF00D;
        repeat (5) @(negedge clk);   // cycle 4: first HI cycle, we_n low
        #1 rst = 1'b1;
        #1;
        vectors++; if (bus1.sram_we_n !== 1'b1 || bus1.sram_oe_n !== 1'b1 || bus1.sram_dq_oe !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_strobes got we_n=%b oe_n=%b dq_oe=%b want 1 1 0", bus1.sram_we_n, bus1.sram_oe_n, bus1.sram_dq_oe); end
        vectors++; if (bus1.rdata !== 32'h0 || bus1.sram_addr !== 18'h0) begin
            miscompares++; $display("FAIL rstmid_regs got rdata=%h addr=%h want 0 0", bus1.rdata, bus1.sram_addr); end
        bus1.wr_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        w0 = wr_cycles;
        repeat (6) @(negedge clk);
        vectors++; if (bus1.ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %b want 1", bus1.ready); end
        vectors++; if (bus1.sram_we_n !== 1'b1 || bus1.sram_oe_n !== 1'b1 || bus1.sram_dq_oe !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_idle got we_n=%b oe_n=%b dq_oe=%b want 1 1 0", bus1.sram_we_n, bus1.sram_oe_n, bus1.sram_dq_oe); end
        vectors++; if (bus1.rdata !== 32'h0) begin miscompares++; $display("FAIL rstmid_rdata got %h want 0", bus1.rdata); end
        vectors++; if (wr_cycles != w0) begin miscompares++; $display("FAIL rstmid_no_writes got %0d want %0d", wr_cycles, w0); end
        vectors++; if (mem[8] !== 16'hF00D) begin miscompares++; $display("FAIL rstmid_lo_done got %h want f00d", mem[8]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_both_enables();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
